// File: rtl/perf_ctrl_pkg.sv
// Shared definitions for the performance-counter controller: opcodes, FSM states
// and the counter slave word map.
package perf_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_START     = 2'b00,
    OP_STOP      = 2'b01,
    OP_CLEAR_ALL = 2'b10,
    OP_SNAPSHOT  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_HI0,
    RD_LO,
    RD_HI1,
    RD_EV,
    RD_CAP,
    RSP
  } state_e;

  localparam logic [1:0] TIME_LO        = 2'd0;
  localparam logic [1:0] TIME_HI        = 2'd1;
  localparam logic [1:0] EVENTS         = 2'd2;
  localparam int         SECTION_STRIDE = 4;

  function automatic logic [4:0] word_addr(input logic [2:0] sec, input logic [1:0] off);
    return 5'(int'(sec) * SECTION_STRIDE + int'(off));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant while enabled, priority rotates to the
// requester after the most recent grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx,
  output logic               grant_any
);

  logic [1:0] ptr_q;

  function automatic int wrap(input int base, input int ofs);
    int s;
    s = base + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req[wrap(int'(ptr_q), i)]) begin
          grant_any                       = 1'b1;
          grant_idx                       = 2'(wrap(int'(ptr_q), i));
          grant[wrap(int'(ptr_q), i)]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          ptr_q <= '0;
    else if (grant_any) ptr_q <= 2'(wrap(int'(grant_idx), 1));
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Arbitrates requester commands onto an Avalon-MM counter slave and returns
// tear-free 64-bit time snapshots.
module perf_counter_ctrl
  import perf_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [3*NUM_REQ-1:0] req_section,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [63:0]          rsp_time,
  output logic [31:0]          rsp_events,
  output logic [4:0]           avm_address,
  output logic                 avm_write,
  output logic                 avm_read,
  output logic                 avm_begintransfer,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata
);

  if (READ_LATENCY != 1 || NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_param
    $error("perf_counter_ctrl: unsupported NUM_REQ/READ_LATENCY");
  end

  state_e       state, state_nxt;
  logic         arb_en, gnt_any;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]   gnt_idx;
  op_e          gnt_op, op_q;
  logic [2:0]   gnt_sec, sec_q;
  logic [1:0]   id_q;
  logic [31:0]  hi0_q, lo_q, hi1_q;
  logic         retry_q;

  assign arb_en = (state == IDLE) && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (arb_en),
    .req       (req_valid),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    gnt_op  = op_e'(req_op[2*int'(gnt_idx) +: 2]);
    gnt_sec = req_section[3*int'(gnt_idx) +: 3];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    avm_address       = '0;
    avm_write         = 1'b0;
    avm_read          = 1'b0;
    avm_begintransfer = 1'b0;
    avm_writedata     = '0;
    case (state)
      IDLE: if (gnt_any) state_nxt = (gnt_op == OP_SNAPSHOT) ? RD_HI0 : WR;
      WR: begin
        avm_write         = 1'b1;
        avm_begintransfer = 1'b1;
        state_nxt         = IDLE;
        case (op_q)
          OP_START: avm_address = word_addr(sec_q, TIME_HI);
          OP_STOP:  avm_address = word_addr(sec_q, TIME_LO);
          default:  avm_writedata = 32'd1;
        endcase
      end
      RD_HI0: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = word_addr(sec_q, TIME_HI);
        state_nxt   = RD_LO;
      end
      RD_LO: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = word_addr(sec_q, TIME_LO);
        state_nxt   = RD_HI1;
      end
      RD_HI1: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = word_addr(sec_q, TIME_HI);
        state_nxt   = RD_EV;
      end
      RD_EV: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = word_addr(sec_q, EVENTS);
        state_nxt   = RD_CAP;
      end
      // A high-word change between the two high reads means lo may have wrapped.
      RD_CAP:  state_nxt = (hi0_q == hi1_q) ? RSP : RD_LO;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RSP);

  // Readdata arrives one cycle after its address, so each read state captures
  // the word requested by the previous state.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_START;
      sec_q      <= '0;
      id_q       <= '0;
      hi0_q      <= '0;
      lo_q       <= '0;
      hi1_q      <= '0;
      retry_q    <= 1'b0;
      rsp_id     <= '0;
      rsp_time   <= '0;
      rsp_events <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          op_q    <= gnt_op;
          sec_q   <= gnt_sec;
          id_q    <= gnt_idx;
          retry_q <= 1'b0;
        end
        // On a retry the previous cycle carried no read; hi0 was refreshed in RD_CAP.
        RD_LO:  if (!retry_q) hi0_q <= avm_readdata;
        RD_HI1: lo_q  <= avm_readdata;
        RD_EV:  hi1_q <= avm_readdata;
        RD_CAP: begin
          if (hi0_q == hi1_q) begin
            rsp_time   <= {hi1_q, lo_q};
            rsp_events <= avm_readdata;
            rsp_id     <= id_q;
          end else begin
            hi0_q   <= hi1_q;
            retry_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Scoreboard bench: a round-robin/latency reference model predicts grants, writes
// and snapshot responses; a negedge monitor checks what the DUT presents.
module tb_perf_counter_ctrl;
  import perf_ctrl_pkg::*;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid, req_ready;
  logic [2*NR-1:0] req_op;
  logic [3*NR-1:0] req_section;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [63:0]     rsp_time;
  logic [31:0]     rsp_events;
  logic [4:0]      avm_address;
  logic            avm_write, avm_read, avm_begintransfer;
  logic [31:0]     avm_writedata, avm_readdata;

  always #5 clk = ~clk;

  perf_counter_ctrl #(.NUM_REQ(NR), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_section(req_section),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_time(rsp_time),
    .rsp_events(rsp_events), .avm_address(avm_address), .avm_write(avm_write),
    .avm_read(avm_read), .avm_begintransfer(avm_begintransfer),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void miss(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen as expected (cycle %0d)", nm, cyc);
  endfunction

  // Counter slave: 1-cycle registered readdata, optional high-word bump on a high read.
  typedef struct {
    int sec; logic [31:0] hi, lo, ev; bit arm; logic [31:0] bhi, blo;
  } poke_t;
  poke_t       poke_q[$];
  poke_t       sp;
  logic [31:0] m_lo[8], m_hi[8], m_ev[8], b_hi[8], b_lo[8];
  bit          b_arm[8];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_lo[i] <= '0; m_hi[i] <= '0; m_ev[i] <= '0;
        b_hi[i] <= '0; b_lo[i] <= '0; b_arm[i] <= 1'b0;
      end
      avm_readdata <= '0;
    end else begin
      if (poke_q.size() > 0) begin
        sp = poke_q.pop_front();
        m_hi[sp.sec] <= sp.hi; m_lo[sp.sec] <= sp.lo; m_ev[sp.sec] <= sp.ev;
        b_arm[sp.sec] <= sp.arm; b_hi[sp.sec] <= sp.bhi; b_lo[sp.sec] <= sp.blo;
      end
      if (avm_read) begin
        case (avm_address[1:0])
          2'd0: avm_readdata <= m_lo[avm_address[4:2]];
          2'd1: begin
            avm_readdata <= m_hi[avm_address[4:2]];
            if (b_arm[avm_address[4:2]]) begin
              m_hi[avm_address[4:2]]  <= b_hi[avm_address[4:2]];
              m_lo[avm_address[4:2]]  <= b_lo[avm_address[4:2]];
              b_arm[avm_address[4:2]] <= 1'b0;
            end
          end
          2'd2:    avm_readdata <= m_ev[avm_address[4:2]];
          default: avm_readdata <= '0;
        endcase
      end
      if (avm_write && avm_address == 5'd0 && avm_writedata[0]) begin
        for (int i = 0; i < 8; i++) begin
          m_lo[i] <= '0; m_hi[i] <= '0; m_ev[i] <= '0; b_arm[i] <= 1'b0;
        end
      end
    end
  end

  bit rdy_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model + monitor.
  typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [1:0] id; logic [63:0] tm; logic [31:0] ev; } rsp_t;
  wr_t        exp_wr[$];
  rsp_t       exp_rsp[$];
  wr_t        ew;
  rsp_t       er;
  int         rr_last = -1, free_at = 0, m_w, m_c;
  bit         wait_rsp = 1'b0, rsp_seen = 1'b0;
  logic [1:0] m_op;
  logic [2:0] m_sec;
  logic [NR-1:0] exp_gnt;

  always @(negedge clk) begin
    if (reset) begin
      exp_wr.delete(); exp_rsp.delete();
      rr_last = -1; free_at = 0; wait_rsp = 1'b0; rsp_seen = 1'b0;
    end else begin
      exp_gnt = '0;
      if (!wait_rsp && cyc >= free_at && |req_valid) begin
        m_w = -1;
        for (int k = 1; k <= NR; k++) begin
          m_c = (rr_last + k) % NR;
          if (m_w < 0 && req_valid[m_c]) m_w = m_c;
        end
        rr_last = m_w;
        exp_gnt[m_w] = 1'b1;
        m_op  = req_op[2*m_w +: 2];
        m_sec = req_section[3*m_w +: 3];
        case (m_op)
          2'd0: begin exp_wr.push_back('{cyc + 1, 5'(m_sec * 4 + 1), 32'd0}); free_at = cyc + 2; end
          2'd1: begin exp_wr.push_back('{cyc + 1, 5'(m_sec * 4), 32'd0});     free_at = cyc + 2; end
          2'd2: begin exp_wr.push_back('{cyc + 1, 5'd0, 32'd1});              free_at = cyc + 2; end
          default: begin
            if (b_arm[m_sec])
              exp_rsp.push_back('{cyc + 10, 2'(m_w), {b_hi[m_sec], b_lo[m_sec]}, m_ev[m_sec]});
            else
              exp_rsp.push_back('{cyc + 6, 2'(m_w), {m_hi[m_sec], m_lo[m_sec]}, m_ev[m_sec]});
            wait_rsp = 1'b1;
          end
        endcase
      end
      if (|req_valid || |req_ready) chk("grant", 64'(req_ready), 64'(exp_gnt));

      if (avm_write) begin
        if (exp_wr.size() == 0) miss("unexpected_write");
        else begin
          ew = exp_wr.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(ew.cyc));
          chk("wr_addr", 64'(avm_address), 64'(ew.addr));
          chk("wr_data", 64'(avm_writedata), 64'(ew.data));
          chk("wr_begintransfer", 64'(avm_begintransfer), 64'd1);
        end
      end else if (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
        miss("write_missing");
        void'(exp_wr.pop_front());
      end
      if (!avm_read && !avm_write) begin
        chk("idle_addr", 64'(avm_address), 64'd0);
        chk("idle_wdata", 64'(avm_writedata), 64'd0);
        chk("idle_begintransfer", 64'(avm_begintransfer), 64'd0);
      end

      if (rsp_valid) begin
        if (exp_rsp.size() == 0) miss("unexpected_rsp");
        else begin
          er = exp_rsp[0];
          if (!rsp_seen) chk("rsp_cycle", 64'(cyc), 64'(er.cyc));
          chk("rsp_id", 64'(rsp_id), 64'(er.id));
          chk("rsp_time", rsp_time, er.tm);
          chk("rsp_events", 64'(rsp_events), 64'(er.ev));
          if (rsp_ready) begin
            void'(exp_rsp.pop_front());
            wait_rsp = 1'b0; free_at = cyc + 1; rsp_seen = 1'b0;
          end else rsp_seen = 1'b1;
        end
      end else if (exp_rsp.size() > 0 && exp_rsp[0].cyc < cyc) begin
        miss("rsp_missing");
        void'(exp_rsp.pop_front());
        wait_rsp = 1'b0; free_at = cyc;
      end
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({pfx, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({pfx, "_rsp_time"}, rsp_time, 64'd0);
    chk({pfx, "_rsp_events"}, 64'(rsp_events), 64'd0);
    chk({pfx, "_avm_strobes"}, 64'({avm_write, avm_read, avm_begintransfer}), 64'd0);
    chk({pfx, "_avm_address"}, 64'(avm_address), 64'd0);
    chk({pfx, "_avm_writedata"}, 64'(avm_writedata), 64'd0);
  endtask

  task automatic issue(input int r, input logic [1:0] op, input logic [2:0] sec);
    bit got;
    got = 1'b0;
    req_valid[r] = 1'b1;
    req_op[2*r +: 2] = op;
    req_section[3*r +: 3] = sec;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    if (!got) miss("accept_timeout");
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (!wait_rsp && cyc >= free_at && exp_wr.size() == 0 && exp_rsp.size() == 0) done = 1'b1;
    end
    if (!done) miss("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic poke(input int s, input logic [31:0] hi, lo, ev, input bit arm,
                      input logic [31:0] bhi, blo);
    poke_q.push_back('{s, hi, lo, ev, arm, bhi, blo});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s;
    logic [1:0]  op;
    logic [31:0] hi;
    bit got;
    reset = 1'b1; req_valid = '0; req_op = '0; req_section = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    issue(1, OP_START, 3'd3);                          // write to address 13
    wait_idle();
    issue(0, OP_CLEAR_ALL, 3'd0);                      // next accept two cycles later
    issue(0, OP_STOP, 3'd5);
    wait_idle();
    poke(2, 32'd5, 32'h0000FFF0, 32'd7, 1'b0, 32'd0, 32'd0);
    issue(2, OP_SNAPSHOT, 3'd2);
    wait_idle();
    poke(4, 32'd5, 32'h00000100, 32'd9, 1'b1, 32'd6, 32'h00000020);
    issue(3, OP_SNAPSHOT, 3'd4);                       // one retry, high word 6
    wait_idle();
    rdy_rand = 1'b1;
    poke(6, 32'hA5A5_0001, 32'h1234_5678, 32'd42, 1'b0, 32'd0, 32'd0);
    issue(0, OP_SNAPSHOT, 3'd6);
    wait_idle();
    rdy_rand = 1'b0;

    // Reset while the snapshot sits in RD_LO.
    poke(1, 32'd3, 32'd4, 32'd5, 1'b0, 32'd0, 32'd0);
    req_valid[1] = 1'b1; req_op[3:2] = OP_SNAPSHOT; req_section[5:3] = 3'd1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
    end
    if (!got) miss("mid_reset_accept");
    @(posedge clk); #1; req_valid[1] = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;

    // All four requesters valid: grants rotate 0,1,2,3,0,... every two cycles.
    fork
      begin issue(0, OP_START, 3'd0); issue(0, OP_START, 3'd4); end
      begin issue(1, OP_START, 3'd1); issue(1, OP_START, 3'd5); end
      begin issue(2, OP_START, 3'd2); issue(2, OP_START, 3'd6); end
      begin issue(3, OP_START, 3'd3); issue(3, OP_START, 3'd7); end
    join
    wait_idle();

    for (int it = 0; it < 60; it++) begin
      r  = $urandom_range(0, NR - 1);
      op = 2'($urandom_range(0, 3));
      s  = $urandom_range(0, 7);
      rdy_rand = 1'($urandom_range(0, 1));
      if (op == OP_SNAPSHOT) begin
        hi = $urandom;
        poke(s, hi, $urandom, $urandom, ($urandom_range(0, 2) == 0), hi + 32'd1, $urandom);
        issue(r, op, 3'(s));
      end else if ($urandom_range(0, 3) == 0) begin
        fork
          issue(r, op, 3'(s));
          issue((r + 1) % NR, OP_STOP, 3'($urandom_range(0, 7)));
        join
      end else begin
        issue(r, op, 3'(s));
      end
      wait_idle();
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_ctrl.md
PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports; legal range 2..4.
REQ-002 Parameter READ_LATENCY, default 1: cycles from avm_address presented to avm_readdata valid; only 1 is supported.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester command valid.
REQ-006 req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 req_op  in  2*NUM_REQ  per-requester opcode: 00 START, 01 STOP, 10 CLEAR_ALL, 11 SNAPSHOT.
REQ-008 req_section  in  3*NUM_REQ  per-requester section index 0..7.
REQ-009 rsp_valid  out  1  snapshot result valid.
REQ-010 rsp_ready  in  1  snapshot result consumed.
REQ-011 rsp_id  out  2  index of the requester owning the result.
REQ-012 rsp_time  out  64  tear-free 64-bit time count of the section.
REQ-013 rsp_events  out  32  event count of the section.
REQ-014 avm_address  out  5  word address to the counter slave.
REQ-015 avm_write / avm_read / avm_begintransfer  out  1 each  Avalon-MM master strobes.
REQ-016 avm_writedata  out  32  write data.
REQ-017 avm_readdata  in  32  read data, registered by the slave.

Function
REQ-018 Slave map for section s: word 4s = time low / STOP; word 4s+1 = time high / START; word 4s+2 = events. A write to word 0 with data bit0=1 is CLEAR_ALL.
REQ-019 FSM states: IDLE, WR, RD_HI0, RD_LO, RD_HI1, RD_EV, RD_CAP, RSP.
REQ-020 A command is accepted only in IDLE: the round-robin arbiter grants one valid requester, asserts its req_ready for exactly one cycle and latches op, section and id.
REQ-021 Round-robin priority starts at the requester after the last granted one; after reset, requester 0 has highest priority.
REQ-022 START, STOP and CLEAR_ALL go IDLE->WR->IDLE. WR lasts one cycle with avm_write=avm_begintransfer=1.
REQ-023 WR addresses and data: START writes address 4s+1, data 0. STOP writes address 4s, data 0. CLEAR_ALL writes address 0, data 1.
REQ-024 Write latency: accepted in cycle N, write strobe in cycle N+1, next acceptance possible in cycle N+2.
REQ-025 SNAPSHOT read sequence, avm_read=avm_begintransfer=1 in each state:
  - RD_HI0 presents address 4s+1.
  - RD_LO presents 4s and captures hi0.
  - RD_HI1 presents 4s+1 and captures lo.
  - RD_EV presents 4s+2 and captures hi1.
REQ-026 RD_CAP captures events and compares hi0 with hi1. If they are equal, go to RSP with rsp_time={hi1,lo}. If they differ, set hi0<=hi1 and go to RD_LO; retry without limit.
REQ-027 Snapshot latency without retry: accepted in cycle N, rsp_valid=1 in cycle N+6. Each retry adds 4 cycles.
REQ-028 In RSP, rsp_valid and the rsp_* fields stay stable until rsp_valid&rsp_ready; then the FSM returns to IDLE in the next cycle. No grants occur outside IDLE.
REQ-029 All avm_* strobes are 0 in IDLE, RD_CAP and RSP. avm_address and avm_writedata are 0 whenever no strobe is asserted.
REQ-030 The block does not enforce that section 0 must be running for other sections to count; ordering of commands is the requesters' responsibility.
REQ-031 Simultaneous req_valid: exactly one grant per IDLE cycle. Other requesters keep req_valid held, and are not dropped.

Reset
REQ-032 When reset=1 at a rising edge, the block goes to IDLE regardless of state, abandoning any in-flight sequence without completing it.
REQ-033 Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_time=0, rsp_events=0, all avm_* outputs=0, arbiter pointer=requester 0.

Structure
REQ-034 Shared package perf_ctrl_pkg holds the opcode encodings, the FSM state enum and the word offsets TIME_LO=0, TIME_HI=1, EVENTS=2, plus SECTION_STRIDE=4.
REQ-035 The round-robin grant logic is one sub-module, rr_arbiter, parameterised by NUM_REQ; it outputs a one-hot grant and updates its pointer on grant.

Verification
REQ-036 The bench models the counter slave with 1-cycle registered readdata.
REQ-037 START from requester 1, section 3: req_ready[1] pulses in cycle N; in cycle N+1 address=13, write=1, data=0.
REQ-038 CLEAR_ALL: a single write to address 0 with data 0x00000001; the next command is accepted 2 cycles later.
REQ-039 SNAPSHOT of section 2 with model values time=0x00000005_0000FFF0, events=7: rsp_valid in cycle N+6 with rsp_time=0x00000005_0000FFF0 and rsp_events=7.
REQ-040 SNAPSHOT where the high word changes from 5 to 6 between RD_HI0 and RD_HI1: exactly one retry, rsp_valid in cycle N+10, rsp_time high word=6.
REQ-041 All 4 requesters valid continuously with START ops: grants follow the order 0,1,2,3,0, one every 2 cycles.
REQ-042 Reset asserted during RD_LO: the next cycle is IDLE with all outputs 0, no rsp_valid, and requester 0 is granted first afterwards.
